sti_load_sched: RTL

Command scheduler sitting in front of the serial transmitter / DAC pixel-writer datapath. Two independent requesters submit packed transmit commands; the scheduler arbitrates round-robin, drives the transmitter's `load`/`pi_*` inputs, and holds them stable for one complete serial frame. It tracks frame start and end on `so_valid`, sequences the terminating `pi_end` handshake against `pixel_finish`, and reports status.

---
 rtl/sti_pkg.sv | 23 ++
 rtl/sti_load_sched_if.sv | 36 +++
 rtl/sti_load_sched_rr_arb2.sv | 29 ++
 rtl/sti_load_sched.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/sti_pkg.sv
// Shared definitions for the STI load scheduler: command-word field positions
// and the scheduler state encoding.
package sti_pkg;

  localparam int CMD_W        = 22;
  localparam int CMD_DATA_LSB = 0;
  localparam int CMD_LEN_LSB  = 16;
  localparam int CMD_FILL     = 18;
  localparam int CMD_MSB      = 19;
  localparam int CMD_LOW      = 20;
  localparam int CMD_END      = 21;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_START,
    S_WAIT_DONE,
    S_GAP,
    S_END_WAIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/sti_load_sched_if.sv
// Request/command, transmitter and status signals of the load scheduler.
// The slave modport is the scheduler's view; master is the environment's.
interface sti_load_sched_if #(parameter int CNT_W = 16);
  import sti_pkg::*;

  logic [1:0]       req;
  logic [CMD_W-1:0] cmd0;
  logic [CMD_W-1:0] cmd1;
  logic [1:0]       gnt;
  logic             load;
  logic [15:0]      pi_data;
  logic [1:0]       pi_length;
  logic             pi_fill;
  logic             pi_msb;
  logic             pi_low;
  logic             pi_end;
  logic             so_valid;
  logic             pixel_finish;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] xfer_cnt;

  modport master (
    output req, cmd0, cmd1, so_valid, pixel_finish,
    input  gnt, load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
           busy, done, err, xfer_cnt
  );

  modport slave (
    input  req, cmd0, cmd1, so_valid, pixel_finish,
    output gnt, load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
           busy, done, err, xfer_cnt
  );

endinterface

// File: rtl/sti_load_sched_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer only moves when a grant is
// actually issued (en high and some request present).
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // last_q = 1 means requester 1 was granted most recently, so 0 wins a tie
  logic last_q, last_d;

  always_comb begin
    gnt    = 2'b00;
    last_d = last_q;
    if (en) begin
      if (req == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
      else              gnt = req;
      if (|req) last_d = gnt[1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/sti_load_sched.sv
// Command scheduler in front of the serial transmitter: arbitrates two
// requesters, loads one command per frame and sequences the end-of-stream.
module sti_load_sched
  import sti_pkg::*;
#(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 16
) (
  input logic              clk,
  input logic              reset,
  sti_load_sched_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [1:0]       arb_gnt;
  logic [1:0]       gnt_q, gnt_d;
  logic             load_q, load_d;
  logic [15:0]      pi_data_q, pi_data_d;
  logic [1:0]       pi_length_q, pi_length_d;
  logic             pi_fill_q, pi_fill_d;
  logic             pi_msb_q, pi_msb_d;
  logic             pi_low_q, pi_low_d;
  logic             pi_end_q, pi_end_d;
  logic             end_bit_q, end_bit_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [CMD_W-1:0] sel_cmd;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (bus.req),
    .en    (state_q == S_IDLE),
    .gnt   (arb_gnt)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = 2'b00;
    load_d      = 1'b0;
    pi_data_d   = pi_data_q;
    pi_length_d = pi_length_q;
    pi_fill_d   = pi_fill_q;
    pi_msb_d    = pi_msb_q;
    pi_low_d    = pi_low_q;
    end_bit_d   = end_bit_q;
    err_d       = err_q;
    xfer_cnt_d  = xfer_cnt_q;
    tmo_d       = tmo_q;
    sel_cmd     = arb_gnt[1] ? bus.cmd1 : bus.cmd0;

    unique case (state_q)
      S_IDLE: begin
        if (|arb_gnt) begin
          gnt_d       = arb_gnt;
          pi_data_d   = sel_cmd[CMD_DATA_LSB +: 16];
          pi_length_d = sel_cmd[CMD_LEN_LSB +: 2];
          pi_fill_d   = sel_cmd[CMD_FILL];
          pi_msb_d    = sel_cmd[CMD_MSB];
          pi_low_d    = sel_cmd[CMD_LOW];
          end_bit_d   = sel_cmd[CMD_END];
          state_d     = S_LOAD;
        end
      end
      S_LOAD: begin
        load_d  = 1'b1;
        tmo_d   = '0;
        state_d = S_WAIT_START;
      end
      // The registered load pulse coincides with the first cycle here, so
      // expiry at TIMEOUT-1 makes err rise exactly TIMEOUT cycles after load.
      S_WAIT_START: begin
        if (bus.so_valid) begin
          state_d = S_WAIT_DONE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.so_valid) begin
          xfer_cnt_d = xfer_cnt_q + 1'b1;
          state_d    = end_bit_q ? S_END_WAIT : S_GAP;
        end
      end
      S_GAP:      state_d = S_IDLE;
      S_END_WAIT: if (bus.pixel_finish) state_d = S_DONE;
      S_DONE:     state_d = S_DONE;
      default:    state_d = S_IDLE;
    endcase

    pi_end_d = (state_d == S_END_WAIT) || (state_d == S_DONE);
    busy_d   = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d   = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      gnt_q       <= 2'b00;
      load_q      <= 1'b0;
      pi_data_q   <= '0;
      pi_length_q <= '0;
      pi_fill_q   <= 1'b0;
      pi_msb_q    <= 1'b0;
      pi_low_q    <= 1'b0;
      pi_end_q    <= 1'b0;
      end_bit_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      xfer_cnt_q  <= '0;
      tmo_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      load_q      <= load_d;
      pi_data_q   <= pi_data_d;
      pi_length_q <= pi_length_d;
      pi_fill_q   <= pi_fill_d;
      pi_msb_q    <= pi_msb_d;
      pi_low_q    <= pi_low_d;
      pi_end_q    <= pi_end_d;
      end_bit_q   <= end_bit_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      xfer_cnt_q  <= xfer_cnt_d;
      tmo_q       <= tmo_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.load      = load_q;
  assign bus.pi_data   = pi_data_q;
  assign bus.pi_length = pi_length_q;
  assign bus.pi_fill   = pi_fill_q;
  assign bus.pi_msb    = pi_msb_q;
  assign bus.pi_low    = pi_low_q;
  assign bus.pi_end    = pi_end_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.xfer_cnt  = xfer_cnt_q;

endmodule
